// File: rtl/pc_seq_4b.sv
// 4-bit program counter sequencer: RUN/HALT FSM with step, jump and conditional jump.
// Define PC_SEQ_CALL_STACK_EN to add call/ret with a 2-entry return-address stack.
module pc_seq_4b #(
    parameter logic [3:0] RESET_ADDR   = 4'd0,
    parameter bit         HALT_ON_WRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_en,
    input  logic       jmp,
    input  logic       jc,
    input  logic       carry,
    input  logic [3:0] JMP_ADDR,
    input  logic       halt_req,
    input  logic       resume,
`ifdef PC_SEQ_CALL_STACK_EN
    input  logic       call,
    input  logic       ret,
    output logic       stk_err,
`endif
    output logic       sel3,
    output logic       sel2,
    output logic       sel1,
    output logic       sel0,
    output logic       halted,
    output logic       wrap
);

    typedef enum logic {RUN, HALT} state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic       halted_q, halted_d;
    logic       wrap_q, wrap_d;

`ifdef PC_SEQ_CALL_STACK_EN
    logic [1:0][3:0] stk_q, stk_d;
    logic [1:0]      sp_q, sp_d;     // number of valid entries, 0..2
    logic            err_q, err_d;
`endif

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        wrap_d  = 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
        stk_d   = stk_q;
        sp_d    = sp_q;
        err_d   = err_q;
`endif
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
`ifdef PC_SEQ_CALL_STACK_EN
                end else if (ret) begin
                    if (sp_q == 2'd0) begin
                        err_d = 1'b1;
                    end else begin
                        // top entry sits at sp-1: index 1 only when two are held
                        pc_d = stk_q[sp_q[1]];
                        sp_d = sp_q - 2'd1;
                    end
                end else if (call) begin
                    if (sp_q == 2'd2) begin
                        err_d = 1'b1;
                    end else begin
                        stk_d[sp_q[0]] = pc_q + 4'd1;
                        sp_d           = sp_q + 2'd1;
                        pc_d           = JMP_ADDR;
                    end
`endif
                end else if (jmp || (jc && carry)) begin
                    pc_d = JMP_ADDR;
                end else if (step_en) begin
                    if (pc_q == 4'd15) begin
                        if (HALT_ON_WRAP) begin
                            state_d = HALT;
                        end else begin
                            pc_d   = 4'd0;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + 4'd1;
                    end
                end
            end
            HALT: begin
                if (resume && !halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_ADDR;
            state_q  <= RUN;
            halted_q <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
            stk_q    <= '0;
            sp_q     <= 2'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            halted_q <= halted_d;
            wrap_q   <= wrap_d;
`ifdef PC_SEQ_CALL_STACK_EN
            stk_q    <= stk_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
`endif
        end
    end

    assign {sel3, sel2, sel1, sel0} = pc_q;
    assign halted = halted_q;
    assign wrap   = wrap_q;
`ifdef PC_SEQ_CALL_STACK_EN
    assign stk_err = err_q;
`endif

endmodule

// File: tb/tb_pc_seq_4b.sv
// Directed bench for pc_seq_4b: one default instance plus a HALT_ON_WRAP instance
// sharing the same stimulus.
module tb_pc_seq_4b;
    logic clk = 1'b0;
    logic rst, step_en, jmp, jc, carry, halt_req, resume;
    logic [3:0] jmp_addr;
    logic s3, s2, s1, s0, halted, wrap;
    logic t3, t2, t1, t0, halted1, wrap1;
    int passes = 0;
    int total  = 0;
`ifdef PC_SEQ_CALL_STACK_EN
    logic call, ret, stk_err, stk_err1;
`endif

    pc_seq_4b dut (
        .clk(clk), .rst(rst), .step_en(step_en), .jmp(jmp), .jc(jc), .carry(carry),
        .JMP_ADDR(jmp_addr), .halt_req(halt_req), .resume(resume),
`ifdef PC_SEQ_CALL_STACK_EN
        .call(call), .ret(ret), .stk_err(stk_err),
`endif
        .sel3(s3), .sel2(s2), .sel1(s1), .sel0(s0), .halted(halted), .wrap(wrap)
    );

    pc_seq_4b #(.RESET_ADDR(4'd14), .HALT_ON_WRAP(1'b1)) dut_hw (
        .clk(clk), .rst(rst), .step_en(step_en), .jmp(jmp), .jc(jc), .carry(carry),
        .JMP_ADDR(jmp_addr), .halt_req(halt_req), .resume(resume),
`ifdef PC_SEQ_CALL_STACK_EN
        .call(call), .ret(ret), .stk_err(stk_err1),
`endif
        .sel3(t3), .sel2(t2), .sel1(t1), .sel0(t0), .halted(halted1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic j, input logic c, input logic cy,
                         input logic [3:0] a, input logic h, input logic r);
        step_en = s; jmp = j; jc = c; carry = cy; jmp_addr = a; halt_req = h; resume = r;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 4'd0, 0, 0);
`ifdef PC_SEQ_CALL_STACK_EN
        call = 1'b0; ret = 1'b0;
`endif
        #12;
        chk("rst_pc", {s3, s2, s1, s0}, 4'd0);
        chk("rst_halted", {3'b0, halted}, 4'd0);
        chk("rst_wrap", {3'b0, wrap}, 4'd0);
        chk("rst_pc_hw", {t3, t2, t1, t0}, 4'd14);
        @(negedge clk);
        rst = 1'b0;

        // 16 steps: 1..15 then 0, wrap only after the 15->0 edge
        drive(1, 0, 0, 0, 4'd0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("step_pc_%0d", i), {s3, s2, s1, s0}, 4'(i % 16));
            chk($sformatf("step_wrap_%0d", i), {3'b0, wrap}, (i == 16) ? 4'd1 : 4'd0);
            if (i == 1) chk("hw_pc15", {t3, t2, t1, t0}, 4'd15);
            if (i == 2) begin
                chk("hw_hold15", {t3, t2, t1, t0}, 4'd15);
                chk("hw_halted", {3'b0, halted1}, 4'd1);
                chk("hw_nowrap", {3'b0, wrap1}, 4'd0);
            end
        end
        drive(0, 0, 0, 0, 4'd0, 0, 0);
        tick();
        chk("wrap_drop", {3'b0, wrap}, 4'd0);
        chk("hold_pc", {s3, s2, s1, s0}, 4'd0);

        // jumps
        drive(0, 1, 0, 0, 4'd5, 0, 0); tick();
        chk("jmp5", {s3, s2, s1, s0}, 4'd5);
        drive(1, 0, 1, 0, 4'd12, 0, 0); tick();
        chk("jc_nocarry", {s3, s2, s1, s0}, 4'd6);
        drive(0, 0, 1, 1, 4'd12, 0, 0); tick();
        chk("jc_carry", {s3, s2, s1, s0}, 4'd12);
        drive(1, 1, 0, 0, 4'd3, 0, 0); tick();
        chk("jmp_over_step", {s3, s2, s1, s0}, 4'd3);
        drive(0, 1, 0, 0, 4'd15, 0, 0); tick();
        drive(1, 1, 0, 0, 4'd0, 0, 0); tick();
        chk("jmp15to0_pc", {s3, s2, s1, s0}, 4'd0);
        chk("jmp15to0_nowrap", {3'b0, wrap}, 4'd0);

        // halt behaviour
        drive(0, 1, 0, 0, 4'd7, 0, 0); tick();
        drive(0, 1, 0, 0, 4'd2, 1, 0); tick();
        chk("halt_pc", {s3, s2, s1, s0}, 4'd7);
        chk("halt_flag", {3'b0, halted}, 4'd1);
        drive(1, 1, 1, 1, 4'd2, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("halt_hold_pc", {s3, s2, s1, s0}, 4'd7);
        drive(0, 0, 0, 0, 4'd0, 1, 1); tick();
        chk("resume_with_halt", {3'b0, halted}, 4'd1);
        drive(1, 0, 0, 0, 4'd0, 0, 1); tick();
        chk("resume_flag", {3'b0, halted}, 4'd0);
        chk("resume_pc", {s3, s2, s1, s0}, 4'd7);
        drive(1, 0, 0, 0, 4'd0, 0, 0); tick();
        chk("post_resume_step", {s3, s2, s1, s0}, 4'd8);

        // async reset mid-HALT
        drive(0, 1, 0, 0, 4'd9, 0, 0); tick();
        drive(0, 0, 0, 0, 4'd0, 1, 0); tick();
        chk("pre_rst_pc", {s3, s2, s1, s0}, 4'd9);
        drive(0, 1, 0, 0, 4'd4, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", {s3, s2, s1, s0}, 4'd0);
        chk("async_rst_halted", {3'b0, halted}, 4'd0);
        chk("async_rst_pc_hw", {t3, t2, t1, t0}, 4'd14);
        #1 rst = 1'b0;
        drive(1, 0, 0, 0, 4'd0, 0, 0); tick();
        chk("post_rst_step", {s3, s2, s1, s0}, 4'd1);

`ifdef PC_SEQ_CALL_STACK_EN
        drive(0, 1, 0, 0, 4'd2, 0, 0); tick();
        drive(0, 0, 0, 0, 4'd10, 0, 0); call = 1'b1; tick();
        chk("call1", {s3, s2, s1, s0}, 4'd10);
        jmp_addr = 4'd14; tick();
        chk("call2", {s3, s2, s1, s0}, 4'd14);
        chk("stk_err_clear", {3'b0, stk_err}, 4'd0);
        jmp_addr = 4'd5; tick();
        chk("call3_pc", {s3, s2, s1, s0}, 4'd14);
        chk("call3_err", {3'b0, stk_err}, 4'd1);
        call = 1'b0; ret = 1'b1; tick();
        chk("ret1", {s3, s2, s1, s0}, 4'd11);
        tick();
        chk("ret2", {s3, s2, s1, s0}, 4'd3);
        tick();
        chk("ret3", {s3, s2, s1, s0}, 4'd3);
        chk("err_sticky", {3'b0, stk_err}, 4'd1);
        ret = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/pc_seq_4b.md
PC_SEQ_4B -- requirements
Module: pc_seq_4b

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 4'd0, meaning the PC value loaded by reset.
REQ-002 SHALL have parameter HALT_ON_WRAP, default 0; 1 means entering HALT instead of wrapping from 15 to 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port step_en, input, 1, advance PC this cycle when RUN.
REQ-006 SHALL have port jmp, input, 1, unconditional jump to JMP_ADDR.
REQ-007 SHALL have port jc, input, 1, jump to JMP_ADDR only if carry=1.
REQ-008 SHALL have port carry, input, 1, ALU carry flag sampled with jc.
REQ-009 SHALL have port JMP_ADDR, input, 4, jump target.
REQ-010 SHALL have port halt_req, input, 1, request to stop fetching.
REQ-011 SHALL have port resume, input, 1, leave HALT.
REQ-012 SHALL have ports sel3, sel2, sel1, sel0, output, 1 each, PC bits 3..0 driving the 16:1 instruction mux selects.
REQ-013 SHALL have port halted, output, 1, high in HALT state.
REQ-014 SHALL have port wrap, output, 1, one-cycle pulse when PC advances 15 -> 0.

Function
REQ-015 SHALL hold a registered 4-bit PC; {sel3,sel2,sel1,sel0} SHALL equal PC directly from flops, no combinational path from inputs.
REQ-016 SHALL implement FSM states RUN and HALT.
REQ-017 In RUN, per edge, priority: halt_req > jmp > (jc & carry) > step_en > hold.
REQ-018 halt_req in RUN -> HALT next cycle, PC unchanged, jump/step in same cycle ignored.
REQ-019 jmp, or jc with carry=1, SHALL load JMP_ADDR (latency 1 cycle) regardless of step_en.
REQ-020 jc with carry=0 SHALL behave as if jc were low (step_en then applies).
REQ-021 step_en SHALL increment PC modulo 16; 15 -> 0 SHALL assert wrap for exactly the following cycle.
REQ-022 With HALT_ON_WRAP=1, a step at PC=15 SHALL instead hold PC=15, enter HALT, no wrap pulse.
REQ-023 A jump to address 0 from 15 SHALL NOT assert wrap.
REQ-024 In HALT, PC SHALL hold; jmp, jc, step_en ignored; resume (with halt_req low) -> RUN next cycle, PC unchanged; resume and halt_req together SHALL stay in HALT.
REQ-025 halted SHALL be registered, high exactly while FSM is HALT.

Reset
REQ-026 rst high SHALL immediately force PC=RESET_ADDR, FSM=RUN, halted=0, wrap=0, call stack empty, regardless of clk.
REQ-027 rst asserted mid-jump or mid-HALT SHALL discard the pending operation; first edge after rst release applies normal RUN rules.

Configuration
REQ-028 Macro PC_SEQ_CALL_STACK_EN SHALL, when defined, add inputs call (1) and ret (1), output stk_err (1), and a 2-entry return-address stack.
REQ-029 With the macro: call in RUN SHALL push PC+1 (mod 16) and load JMP_ADDR; ret SHALL pop into PC; priority halt_req > ret > call > jmp > jc > step_en.
REQ-030 With the macro: call with 2 entries full or ret with stack empty SHALL leave PC and stack unchanged and assert stk_err sticky until reset.
REQ-031 Without the macro: no call/ret/stk_err ports, no stack flops; behaviour per REQ-017..REQ-025 only.

Verification
REQ-032 Reset then 16 cycles step_en=1 -> selects 0,1,...,15,0; wrap high only the cycle after 15 -> 0.
REQ-033 PC=5, jc=1 carry=0 step_en=1 -> PC=6; jc=1 carry=1 JMP_ADDR=12 -> PC=12; jmp=1 and step_en=1 same cycle, JMP_ADDR=3 -> PC=3.
REQ-034 PC=7, halt_req=1 with jmp=1 -> halted=1, PC=7; step/jmp for 4 cycles -> PC=7; resume=1 -> halted=0, next step -> PC=8.
REQ-035 HALT_ON_WRAP=1, PC=15, step_en=1 -> PC=15, halted=1, wrap=0.
REQ-036 rst pulsed between clock edges while PC=9 in HALT -> PC=RESET_ADDR and halted=0 before next edge.
REQ-037 (PC_SEQ_CALL_STACK_EN) PC=2 call JMP_ADDR=10, PC=10 call JMP_ADDR=14, third call -> stk_err=1, PC=14; ret -> PC=11, ret -> PC=3, ret -> PC=3 unchanged.
